// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: synchronous-read IMEM front end with a 2-entry output FIFO.
// Optional performance counters are enabled by defining IMEM_FETCH_PERF_CNT_EN.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  output logic        mem_en,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef IMEM_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_ent_t;

  logic [31:0] r_fetch_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  fetch_ent_t  r_buf [BUF_DEPTH];
  logic [1:0]  r_count;

  logic        w_pop;
  logic        w_push;
  logic [2:0]  w_occ;
  logic        w_issue_ok;
  logic        w_wr_idx;

  // Occupancy the next cycle will see if nothing new is issued now.
  assign w_pop      = inst_valid && inst_ready;
  assign w_occ      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue_ok = rst_n && (w_occ <= 3'd1);
  assign w_push     = r_inflight && !redirect_valid;
  assign w_wr_idx   = w_pop ? r_count[1] : r_count[0];

  assign mem_addr   = redirect_valid ? {redirect_pc[31:2], 2'b00} : r_fetch_pc;
  assign mem_en     = rst_n && (w_issue_ok || redirect_valid);

  assign inst_valid = (r_count != 2'd0) && !redirect_valid;
  assign inst       = r_buf[0].word;
  assign inst_pc    = r_buf[0].pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
    end else begin
      r_inflight <= mem_en;
      if (mem_en) begin
        r_inflight_pc <= mem_addr;
        r_fetch_pc    <= mem_addr + 32'd4;
      end
    end
  end

  // Head lives in slot 0; a pop shifts, a push lands behind the surviving entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) begin
          r_buf[i] <= r_buf[i+1];
        end
      end
      if (w_push) begin
        r_buf[w_wr_idx].pc   <= r_inflight_pc;
        r_buf[w_wr_idx].word <= mem_rdata;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

`ifdef IMEM_FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (w_push)                   fetch_cnt <= fetch_cnt + 32'd1;
      if (inst_valid && !inst_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, fixed at 2: output buffer entries; other values are unsupported.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 mem_addr  out  32  byte address driven to the synchronous-read instruction memory; word data returns on mem_rdata one cycle later.
REQ-006 mem_en  out  1  high when the current mem_addr is a real fetch whose data is to be kept.
REQ-007 mem_rdata  in  32  instruction word read for the mem_addr of the previous cycle.
REQ-008 redirect_valid  in  1  branch/jump/trap redirect strobe.
REQ-009 redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
REQ-010 inst_valid  out  1  inst/inst_pc hold a valid fetched instruction.
REQ-011 inst_ready  in  1  consumer accepts; transfer when inst_valid && inst_ready.
REQ-012 inst  out  32  fetched instruction word (buffer head).
REQ-013 inst_pc  out  32  address of inst.

Function
REQ-014 The block SHALL keep fetch_pc, a 1-bit in-flight flag tagged with its pc, and a 2-entry FIFO of {pc, word}.
REQ-015 Pop = inst_valid && inst_ready && !redirect_valid; issue allowed when buf_count + inflight - pop <= 1 and not in reset.
REQ-016 mem_addr SHALL be combinational: redirect_pc&~3 when redirect_valid, else fetch_pc; mem_en = issue allowed or redirect_valid.
REQ-017 On issue, fetch_pc SHALL become mem_addr + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000; in-flight set with pc = mem_addr.
REQ-018 When in-flight is set and not killed, mem_rdata with its tag pc SHALL be pushed into the FIFO at the next posedge.
REQ-019 inst_valid = (buf_count != 0) && !redirect_valid; inst/inst_pc are the FIFO head.
REQ-020 Redirect: in the same cycle FIFO SHALL be cleared, in-flight data discarded (not pushed), no transfer counted, and redirect_pc fetched immediately.
REQ-021 Redirect-to-first inst_valid latency SHALL be exactly 2 cycles; sustained throughput SHALL be 1 instruction/cycle with inst_ready held high.
REQ-022 inst_ready low SHALL hold inst/inst_pc stable; FIFO never overflows; fetching stops when FIFO plus in-flight reaches 2.
REQ-023 Simultaneous push and pop SHALL keep buf_count unchanged and preserve order.
REQ-024 Redirect while FIFO full and inst_ready low SHALL still take effect (redirect has priority over all).

Reset
REQ-025 While rst_n low: inst_valid=0, inst=0, inst_pc=0, mem_en=0, FIFO empty, in-flight clear, fetch_pc=RESET_PC.
REQ-026 First cycle after rst_n rises SHALL issue RESET_PC (mem_en=1); inst_valid first rises 2 cycles later.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions immediately.

Configuration
REQ-028 Macro IMEM_FETCH_PERF_CNT_EN: when defined, add outputs fetch_cnt[31:0] (increments on each push) and stall_cnt[31:0] (increments each cycle inst_valid && !inst_ready), both reset to 0, wrap at 2^32.
REQ-029 Without IMEM_FETCH_PERF_CNT_EN the ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 Reset release, RESET_PC=0, inst_ready=1 -> mem_addr 0,4,8,... each cycle; inst_valid from cycle 2 with inst_pc 0,4,8 and matching words, no gaps.
REQ-031 inst_ready low for 5 cycles after first valid -> mem_en drops after FIFO+in-flight=2; inst_pc stays 0; on release pcs 0,4,8 continue with no loss or duplicate.
REQ-032 redirect_valid with redirect_pc=32'h0000_0103 while FIFO full -> that cycle inst_valid=0, mem_addr=0x100; 2 cycles later inst_pc=0x100, then 0x104; no stale pc appears.
REQ-033 fetch_pc at 32'hFFFF_FFF8 via redirect -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-034 rst_n asserted while FIFO holds 2 entries -> inst_valid=0 asynchronously; after release refetch from RESET_PC.
REQ-035 With IMEM_FETCH_PERF_CNT_EN, 10 accepted fetches plus 3 stall cycles, no redirect -> fetch_cnt >= 10, stall_cnt=3.
